// File: rtl/fsm_monitor_if.sv
// Signal bundle between the monitored 4-state FSM and its passive checker.
// master = FSM/observer side, slave = the monitor itself.
interface fsm_monitor_if #(
   parameter int CNT_W   = 8,
   parameter int DWELL_W = 8
);
   logic [1:0]         estados_in;
   logic [1:0]         data_out_in;
   logic               clear;
   logic [CNT_W-1:0]   trans_count;
   logic [CNT_W-1:0]   illegal_count;
   logic               illegal_flag;
   logic [1:0]         illegal_from;
   logic [1:0]         illegal_to;
   logic               out_mismatch;
   logic [DWELL_W-1:0] dwell;
   logic               stuck;

   modport master (
      output estados_in, data_out_in, clear,
      input  trans_count, illegal_count, illegal_flag, illegal_from,
             illegal_to, out_mismatch, dwell, stuck
   );

   modport slave (
      input  estados_in, data_out_in, clear,
      output trans_count, illegal_count, illegal_flag, illegal_from,
             illegal_to, out_mismatch, dwell, stuck
   );
endinterface

// File: rtl/fsm_monitor.sv
// Passive checker for the 4-state safe FSM: transition-graph and output-map
// checks, saturating event counters, dwell timer and first-fault capture.
module fsm_monitor #(
   parameter int CNT_W       = 8,
   parameter int DWELL_W     = 8,
   parameter int STUCK_LIMIT = 200
) (
   input  logic          clk,
   input  logic          reset,
   fsm_monitor_if.slave  mon
);

   typedef enum logic {MON_IDLE = 1'b0, MON_RUN = 1'b1} mon_state_e;

   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;
   localparam logic [1:0] S2 = 2'd2;
   localparam logic [1:0] S3 = 2'd3;

   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [DWELL_W-1:0] DW_ONE   = DWELL_W'(1);
   localparam logic [DWELL_W-1:0] STUCK_TH = DWELL_W'(STUCK_LIMIT);

   mon_state_e         state_q;
   logic [1:0]         prev_q;
   logic [CNT_W-1:0]   trans_q, ill_cnt_q;
   logic               flag_q;
   logic [1:0]         from_q, to_q;
   logic               mismatch_q;
   logic [DWELL_W-1:0] dwell_q;

   logic [CNT_W-1:0]   trans_d, ill_cnt_d;
   logic [DWELL_W-1:0] dwell_d;
   logic [1:0]         cur;
   logic [1:0]         map_exp;
   logic               legal;

   // Any state may fall back to S0: that is the upstream FSM's own reset path.
   function automatic logic is_legal(input logic [1:0] p, input logic [1:0] c);
      logic ok;
      ok = 1'b0;
      if (c == S0) ok = 1'b1;
      else begin
         case (p)
            S0: ok = (c == S1);
            S1: ok = (c == S1) || (c == S2);
            S2: ok = (c == S1) || (c == S3);
            S3: ok = (c == S2) || (c == S3);
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   function automatic logic [1:0] out_map(input logic [1:0] s);
      logic [1:0] m;
      case (s)
         S0: m = 2'b01;
         S1: m = 2'b10;
         S2: m = 2'b11;
         default: m = 2'b00;
      endcase
      return m;
   endfunction

   assign cur     = mon.estados_in;
   assign map_exp = out_map(cur);
   assign legal   = is_legal(prev_q, cur);

   // Saturating next values: an all-ones counter holds.
   assign trans_d   = (trans_q   == '1) ? trans_q   : trans_q   + CNT_ONE;
   assign ill_cnt_d = (ill_cnt_q == '1) ? ill_cnt_q : ill_cnt_q + CNT_ONE;
   assign dwell_d   = (dwell_q   == '1) ? dwell_q   : dwell_q   + DW_ONE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= MON_IDLE;
         prev_q     <= S0;
         trans_q    <= '0;
         ill_cnt_q  <= '0;
         flag_q     <= 1'b0;
         from_q     <= 2'd0;
         to_q       <= 2'd0;
         mismatch_q <= 1'b0;
         dwell_q    <= '0;
      end else if (mon.clear) begin
         state_q    <= MON_IDLE;
         prev_q     <= S0;
         trans_q    <= '0;
         ill_cnt_q  <= '0;
         flag_q     <= 1'b0;
         from_q     <= 2'd0;
         to_q       <= 2'd0;
         mismatch_q <= 1'b0;
         dwell_q    <= '0;
      end else begin
         mismatch_q <= (mon.data_out_in != map_exp);
         case (state_q)
            MON_IDLE: begin
               // First sample only seeds prev_q; there is no pair to judge yet.
               prev_q  <= cur;
               dwell_q <= '0;
               state_q <= MON_RUN;
            end
            MON_RUN: begin
               if (cur != prev_q) begin
                  trans_q <= trans_d;
                  dwell_q <= '0;
               end else begin
                  dwell_q <= dwell_d;
               end
               if (!legal) begin
                  ill_cnt_q <= ill_cnt_d;
                  flag_q    <= 1'b1;
                  if (!flag_q) begin
                     from_q <= prev_q;
                     to_q   <= cur;
                  end
               end
               prev_q <= cur;
            end
         endcase
      end
   end

   assign mon.trans_count   = trans_q;
   assign mon.illegal_count = ill_cnt_q;
   assign mon.illegal_flag  = flag_q;
   assign mon.illegal_from  = from_q;
   assign mon.illegal_to    = to_q;
   assign mon.out_mismatch  = mismatch_q;
   assign mon.dwell         = dwell_q;
   // Derived straight from the dwell register so the two always agree.
   assign mon.stuck         = (dwell_q >= STUCK_TH);

endmodule

// File: tb/tb_fsm_monitor.sv
// Scoreboard bench for fsm_monitor: directed vectors push hand-computed
// expectations tagged with the edge they apply to; a monitor pops and checks.
module tb_fsm_monitor;

   localparam int CNT_W = 8, DWELL_W = 8, STUCK_LIMIT = 200;
   localparam int F_TC = 0, F_IC = 1, F_FL = 2, F_FR = 3, F_TO = 4, F_MM = 5, F_DW = 6, F_SK = 7;

   typedef struct { int tag; int fld; int val; } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   edges = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   exp_t q[$];

   fsm_monitor_if #(.CNT_W(CNT_W), .DWELL_W(DWELL_W)) bus ();

   fsm_monitor #(.CNT_W(CNT_W), .DWELL_W(DWELL_W), .STUCK_LIMIT(STUCK_LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .mon   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] mp(input logic [1:0] s);
      logic [1:0] m;
      case (s)
         2'd0: m = 2'b01;
         2'd1: m = 2'b10;
         2'd2: m = 2'b11;
         default: m = 2'b00;
      endcase
      return m;
   endfunction

   function automatic int actual(input int fld);
      int a;
      case (fld)
         F_TC: a = int'(bus.trans_count);
         F_IC: a = int'(bus.illegal_count);
         F_FL: a = int'(bus.illegal_flag);
         F_FR: a = int'(bus.illegal_from);
         F_TO: a = int'(bus.illegal_to);
         F_MM: a = int'(bus.out_mismatch);
         F_DW: a = int'(bus.dwell);
         default: a = int'(bus.stuck);
      endcase
      return a;
   endfunction

   function automatic string fname(input int fld);
      string s;
      case (fld)
         F_TC: s = "trans_count";
         F_IC: s = "illegal_count";
         F_FL: s = "illegal_flag";
         F_FR: s = "illegal_from";
         F_TO: s = "illegal_to";
         F_MM: s = "out_mismatch";
         F_DW: s = "dwell";
         default: s = "stuck";
      endcase
      return s;
   endfunction

   task automatic chk(input int fld, input int val);
      int a;
      a = actual(fld);
      n_vec++;
      if (a != val) begin
         n_bad++;
         $display("FAIL %s at edge %0d t=%0t: got %0d, want %0d", fname(fld), edges, $time, a, val);
      end
   endtask

   // Monitor: expectations tagged with edge N are checked 1ns after edge N.
   always begin
      exp_t e;
      @(posedge clk);
      edges++;
      #1;
      while (q.size() > 0 && q[0].tag <= edges) begin
         e = q.pop_front();
         chk(e.fld, e.val);
      end
   end

   task automatic push(input int fld, input int val);
      exp_t e;
      if (val >= 0) begin
         e.tag = edges + 1; e.fld = fld; e.val = val;
         q.push_back(e);
      end
   endtask

   // Drive one vector at a negedge, queue what the next posedge must show (-1 = don't care).
   task automatic step(input logic [1:0] st, input logic [1:0] d, input logic c,
                       input int tc, input int ic, input int fl, input int fr,
                       input int to, input int mm, input int dw, input int sk);
      bus.estados_in  = st;
      bus.data_out_in = d;
      bus.clear       = c;
      push(F_TC, tc); push(F_IC, ic); push(F_FL, fl); push(F_FR, fr);
      push(F_TO, to); push(F_MM, mm); push(F_DW, dw); push(F_SK, sk);
      @(negedge clk);
   endtask

   task automatic chk_all_zero();
      for (int f = F_TC; f <= F_SK; f++) chk(f, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] seq1 [7];
      int         tc1  [7];
      int         dw1  [7];
      seq1 = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
      tc1  = '{0, 1, 1, 2, 3, 3, 4};
      dw1  = '{0, 0, 1, 0, 0, 1, 0};

      bus.estados_in = 2'd0; bus.data_out_in = 2'b01; bus.clear = 1'b0;
      #2;
      chk_all_zero();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Legal walk with correct outputs.
      for (int i = 0; i < 7; i++)
         step(seq1[i], mp(seq1[i]), 1'b0, tc1[i], 0, 0, -1, -1, 0, dw1[i], 0);

      // Illegal S0->S2, S2->S2, S3->S1; capture keeps the first pair.
      step(2'd0, mp(2'd0), 1'b0, 5, 0, 0, 0, 0, 0, 0, -1);
      step(2'd2, mp(2'd2), 1'b0, 6, 1, 1, 0, 2, 0, 0, -1);
      step(2'd2, mp(2'd2), 1'b0, 6, 2, 1, 0, 2, 0, 1, -1);
      step(2'd3, mp(2'd3), 1'b0, 7, 2, 1, 0, 2, 0, 0, -1);
      step(2'd1, mp(2'd1), 1'b0, 8, 3, 1, 0, 2, 0, 0, -1);

      // Dwell and stuck over a 210-cycle hold of S3.
      step(2'd2, mp(2'd2), 1'b0, 9, 3, -1, -1, -1, 0, 0, 0);
      step(2'd3, mp(2'd3), 1'b0, 10, 3, -1, -1, -1, 0, 0, 0);
      for (int k = 1; k <= 210; k++)
         step(2'd3, mp(2'd3), 1'b0, 10, -1, -1, -1, -1, -1, k, (k >= STUCK_LIMIT) ? 1 : 0);
      step(2'd2, mp(2'd2), 1'b0, 11, 3, -1, -1, -1, 0, 0, 0);

      // One-cycle output mismatch.
      step(2'd1, 2'b01, 1'b0, 12, 3, -1, -1, -1, 1, 0, -1);
      step(2'd1, mp(2'd1), 1'b0, 12, 3, -1, -1, -1, 0, 1, -1);

      // Toggle S2/S1 until trans_count saturates.
      for (int i = 1; i <= 300; i++)
         step((i % 2 == 1) ? 2'd2 : 2'd1, (i % 2 == 1) ? mp(2'd2) : mp(2'd1), 1'b0,
              (12 + i > 255) ? 255 : 12 + i, 3, -1, -1, -1, -1, 0, -1);

      // Clear collides with illegal S1->S3 and a wrong output: clear wins.
      step(2'd3, 2'b01, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(2'd1, mp(2'd1), 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(2'd3, mp(2'd3), 1'b0, 1, 1, 1, 1, 3, 0, 0, -1);
      step(2'd1, mp(2'd1), 1'b0, 2, 2, 1, 1, 3, 0, 0, -1);

      // Asynchronous reset mid-run, no clock edge needed.
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero();
      @(negedge clk);
      reset = 1'b1;
      step(2'd3, mp(2'd3), 1'b0, 0, 0, 0, 0, 0, 0, 0, -1);
      step(2'd2, mp(2'd2), 1'b0, 1, 0, 0, -1, -1, 0, 0, -1);

      repeat (2) @(negedge clk);
      n_vec++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
